// File: rtl/hdc_pkg.sv
// hdc_pkg: shared types, default parameters and saturating counter step for the HDC class generator.
package hdc_pkg;
  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ACCUM, S_BINARIZE, S_DONE} class_gen_state_t;
  localparam int HDC_DIM = 1024;
  localparam int HDC_CHUNK = 64;
  localparam int HDC_CNT_W = 8;
  localparam int HDC_NUM_CLASSES = 10;
  function automatic int sat_step(input int acc, input logic up, input int w);
    int lo, hi, r;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
    r = up ? acc + 1 : acc - 1;
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/bundle_chunk.sv
// bundle_chunk: bipolar saturating add of one hypervector chunk into its signed accumulators.
module bundle_chunk
  import hdc_pkg::*;
#(
  parameter int CHUNK = HDC_CHUNK,
  parameter int CNT_W = HDC_CNT_W
) (
  input  logic [CHUNK*CNT_W-1:0] acc_i,
  input  logic [CHUNK-1:0]       hv_i,
  output logic [CHUNK*CNT_W-1:0] acc_o
);
  always_comb begin
    acc_o = '0;
    for (int i = 0; i < CHUNK; i++)
      acc_o[i*CNT_W +: CNT_W] = CNT_W'(sat_step(int'($signed(acc_i[i*CNT_W +: CNT_W])), hv_i[i], CNT_W));
  end
endmodule

// File: rtl/class_hv_gen.sv
// class_hv_gen: accumulates bipolar training samples per class and binarizes them into class hypervectors.
// Optional HDC_CLASS_CNT_EN adds per-class sample counters (class_cnt, empty_class).
module class_hv_gen
  import hdc_pkg::*;
#(
  parameter int DIM = HDC_DIM,
  parameter int NUM_CLASSES = HDC_NUM_CLASSES,
  parameter int CHUNK = HDC_CHUNK,
  parameter int CNT_W = HDC_CNT_W,
  localparam int NCH = DIM / CHUNK,
  localparam int CLS_W = $clog2(NUM_CLASSES),
  localparam int CH_W = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             start_class_gen,
  input  logic [DIM-1:0]   enc_hv,
  input  logic [CLS_W-1:0] enc_label,
  input  logic             train_last,
  output logic             busy,
  output logic             class_gen_done,
  output logic             overrun,
  output logic             label_err,
  input  logic             rd_en,
  input  logic [CLS_W-1:0] rd_class,
  input  logic [CH_W-1:0]  rd_chunk,
  output logic [CHUNK-1:0] rd_data
`ifdef HDC_CLASS_CNT_EN
  ,
  output logic [15:0]      class_cnt,
  output logic             empty_class
`endif
);
  localparam int AW = CHUNK * CNT_W;
  class_gen_state_t state_q, state_d;
  logic [CLS_W-1:0] cls_q, cls_d, lbl_q, lbl_d, row;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [DIM-1:0] hv_q, hv_d;
  logic last_q, last_d, overrun_q, overrun_d, label_err_q, label_err_d;
  logic [CHUNK-1:0] rd_q, bin;
  logic [AW-1:0] acc_mem [NUM_CLASSES][NCH];
  logic [CHUNK-1:0] cls_mem [NUM_CLASSES][NCH];
  logic [AW-1:0] acc_rd, acc_upd;
  logic lbl_ok, accept, end_ch, end_scan;
  assign row = state_q == S_ACCUM ? lbl_q : cls_q;
  assign acc_rd = acc_mem[row][ch_q];
  bundle_chunk #(.CHUNK(CHUNK), .CNT_W(CNT_W)) u_bundle (
    .acc_i(acc_rd),
    .hv_i (hv_q[ch_q*CHUNK +: CHUNK]),
    .acc_o(acc_upd)
  );
  always_comb begin
    bin = '0;
    for (int i = 0; i < CHUNK; i++) bin[i] = $signed(acc_rd[i*CNT_W +: CNT_W]) > 0;
  end
  always_comb begin
    lbl_ok = int'(enc_label) < NUM_CLASSES;
    accept = state_q == S_IDLE && start_class_gen && lbl_ok;
    end_ch = ch_q == CH_W'(NCH - 1);
    end_scan = end_ch && cls_q == CLS_W'(NUM_CLASSES - 1);
    busy = state_q inside {S_CLEAR, S_ACCUM, S_BINARIZE} || accept;
    state_d = state_q;
    cls_d = cls_q;
    ch_d = ch_q;
    hv_d = hv_q;
    lbl_d = lbl_q;
    last_d = last_q;
    overrun_d = overrun_q | (start_class_gen && state_q != S_IDLE);
    label_err_d = label_err_q | (start_class_gen && state_q == S_IDLE && !lbl_ok);
    if (clr) begin
      state_d = S_CLEAR;
      cls_d = '0;
      ch_d = '0;
      overrun_d = 1'b0;
      label_err_d = 1'b0;
    end else begin
      case (state_q)
        S_CLEAR, S_BINARIZE: begin
          ch_d = end_ch ? '0 : ch_q + CH_W'(1);
          cls_d = end_scan ? '0 : end_ch ? cls_q + CLS_W'(1) : cls_q;
          if (end_scan) state_d = state_q == S_CLEAR ? S_IDLE : S_DONE;
        end
        S_IDLE: begin
          if (accept) begin
            hv_d = enc_hv;
            lbl_d = enc_label;
            last_d = train_last;
            ch_d = '0;
            state_d = S_ACCUM;
          end else if (start_class_gen && train_last) state_d = S_BINARIZE;
        end
        S_ACCUM: begin
          ch_d = end_ch ? '0 : ch_q + CH_W'(1);
          if (end_ch) state_d = last_q ? S_BINARIZE : S_IDLE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_CLEAR;
      cls_q <= '0;
      ch_q <= '0;
      hv_q <= '0;
      lbl_q <= '0;
      last_q <= 1'b0;
      overrun_q <= 1'b0;
      label_err_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      ch_q <= ch_d;
      hv_q <= hv_d;
      lbl_q <= lbl_d;
      last_q <= last_d;
      overrun_q <= overrun_d;
      label_err_q <= label_err_d;
      rd_q <= (state_q != S_DONE || clr) ? '0 :
              rd_en ? (int'(rd_class) < NUM_CLASSES ? cls_mem[rd_class][rd_chunk] : '0) : rd_q;
    end
  end
  // Storage is deliberately unreset: S_CLEAR and S_BINARIZE rewrite it before use.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) acc_mem[cls_q][ch_q] <= '0;
    if (state_q == S_ACCUM) acc_mem[lbl_q][ch_q] <= acc_upd;
    if (state_q == S_BINARIZE) cls_mem[cls_q][ch_q] <= bin;
  end
  assign class_gen_done = state_q == S_DONE;
  assign overrun = overrun_q;
  assign label_err = label_err_q;
  assign rd_data = rd_q;
`ifdef HDC_CLASS_CNT_EN
  logic [15:0] cnt_q [NUM_CLASSES];
  logic [15:0] class_cnt_q;
  logic any_zero;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < NUM_CLASSES; k++) cnt_q[k] <= '0;
      class_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CLASSES; k++)
        if (state_q == S_CLEAR) cnt_q[k] <= '0;
        else if (accept && !clr && int'(enc_label) == k && cnt_q[k] != '1) cnt_q[k] <= cnt_q[k] + 16'd1;
      class_cnt_q <= (state_q != S_DONE || clr) ? '0 :
                     rd_en ? (int'(rd_class) < NUM_CLASSES ? cnt_q[rd_class] : '0) : class_cnt_q;
    end
  end
  always_comb begin
    any_zero = 1'b0;
    for (int k = 0; k < NUM_CLASSES; k++) if (cnt_q[k] == '0) any_zero = 1'b1;
  end
  assign class_cnt = class_cnt_q;
  assign empty_class = any_zero && state_q == S_DONE;
`endif
endmodule
